// File: rtl/accel_pkg.sv
// Shared accelerator definitions: loader state encoding and buffer
// footprint arithmetic, reused by the ifmap loader and ofmap writeback.
package accel_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Words occupied by a width x width input feature map.
    function automatic logic [31:0] ifmap_words(input logic [15:0] width);
        return {16'd0, width} * {16'd0, width};
    endfunction

    // Words occupied by the (width-2) x (width-2) output map of a 3x3 kernel.
    // Underflows for width < 2, but such widths are rejected before use.
    function automatic logic [31:0] ofmap_words(input logic [15:0] width);
        logic [15:0] side;
        side = width - 16'd2;
        return {16'd0, side} * {16'd0, side};
    endfunction

    // True when both maps fit in a buffer of `depth` words and the map is
    // at least one kernel wide. The sum is carried in 33 bits so that very
    // large widths cannot wrap around into an apparently small footprint.
    function automatic logic footprint_ok(input logic [15:0] width,
                                          input logic [31:0] depth);
        logic [32:0] total;
        total = {1'b0, ifmap_words(width)} + {1'b0, ofmap_words(width)};
        if (width < 16'd3) begin
            return 1'b0;
        end else begin
            return (total <= {1'b0, depth});
        end
    endfunction

endpackage

// File: rtl/ifmap_loader.sv
// Input feature map loader: accepts a square ifmap over a valid/ready
// stream, writes it to the local buffer from address 0, then kicks the
// router and waits for its completion flag.
module ifmap_loader
    import accel_pkg::*;
#(
    parameter int dataSize    = 8,
    parameter int numRegister = 256
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [dataSize-1:0]            s_data_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic [15:0]                    cfg_ifmap_width,
    input  logic                           cfg_start_i,
    output logic [dataSize-1:0]            wr_data_o,
    output logic [$clog2(numRegister)-1:0] wr_addr_o,
    output logic                           wr_en_o,
    output logic                           ctrl_start_o,
    input  logic                           flag_done_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int          nAddress = $clog2(numRegister);
    localparam logic [31:0] DEPTH    = 32'(numRegister);

    // FSM state and registered status outputs
    state_e                state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic                  ctrl_start_q, ctrl_start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Datapath registers
    logic [nAddress-1:0]   counter_q, counter_d;
    logic [15:0]           width_q, width_d;
    logic                  wr_en_q, wr_en_d;
    logic [nAddress-1:0]   wr_addr_q, wr_addr_d;
    logic [dataSize-1:0]   wr_data_q, wr_data_d;

    // Decoded control
    logic                  cfg_ok_s;
    logic                  cfg_accept_s;
    logic                  cfg_reject_s;
    logic                  xfer_s;
    logic [31:0]           ifmap_words_s;
    logic [nAddress-1:0]   last_idx_s;
    logic                  last_pix_s;

    // Handshake, configuration decode and last-pixel detection
    always_comb begin
        cfg_ok_s      = footprint_ok(cfg_ifmap_width, DEPTH);
        cfg_accept_s  = (state_q == S_IDLE) && cfg_start_i && cfg_ok_s;
        cfg_reject_s  = (state_q == S_IDLE) && cfg_start_i && !cfg_ok_s;
        xfer_s        = s_valid_i && s_ready_q;
        ifmap_words_s = ifmap_words(width_q);
        // Truncation is safe: an accepted width always fits the buffer.
        last_idx_s    = nAddress'(ifmap_words_s - 32'd1);
        last_pix_s    = xfer_s && (counter_q == last_idx_s);
    end

    // Next-state logic and next values of the registered status outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_accept_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (last_pix_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flag_done_i) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        s_ready_d    = (state_d == S_LOAD);
        ctrl_start_d = (state_d == S_START);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        err_d        = cfg_reject_s;
    end

    // FSM register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            s_ready_q    <= 1'b0;
            ctrl_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            ctrl_start_q <= ctrl_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Pixel counter, latched width and buffer write port next values
    always_comb begin
        counter_d = counter_q;
        width_d   = width_q;
        if (cfg_accept_s) begin
            counter_d = '0;
            width_d   = cfg_ifmap_width;
        end else if (xfer_s) begin
            counter_d = counter_q + nAddress'(1);
        end else begin
            counter_d = counter_q;
        end
        wr_en_d = xfer_s;
        if (xfer_s) begin
            wr_addr_d = counter_q;
            wr_data_d = s_data_i;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // Datapath register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            counter_q <= '0;
            width_q   <= 16'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            counter_q <= counter_d;
            width_q   <= width_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign s_ready_o    = s_ready_q;
    assign ctrl_start_o = ctrl_start_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_ifmap_loader.sv
// Scoreboard bench for ifmap_loader: jobs push their expected buffer
// writes into a queue, an independent monitor pops and compares them.
module tb_ifmap_loader;

    localparam int DW = 8;
    localparam int NR = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [15:0]   cfg_ifmap_width;
    logic          cfg_start_i;
    logic [DW-1:0] wr_data_o;
    logic [AW-1:0] wr_addr_o;
    logic          wr_en_o;
    logic          ctrl_start_o;
    logic          flag_done_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    always #5 clk = ~clk;

    ifmap_loader #(.dataSize(DW), .numRegister(NR)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .s_data_i       (s_data_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .cfg_ifmap_width(cfg_ifmap_width),
        .cfg_start_i    (cfg_start_i),
        .wr_data_o      (wr_data_o),
        .wr_addr_o      (wr_addr_o),
        .wr_en_o        (wr_en_o),
        .ctrl_start_o   (ctrl_start_o),
        .flag_done_i    (flag_done_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    typedef struct {
        int addr;
        int data;
        bit last;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ctrl_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rule: both maps must fit the buffer and width >= 3.
    function automatic bit fits(input int w);
        longint a;
        longint b;
        a = longint'(w) * longint'(w);
        b = longint'(w - 2) * longint'(w - 2);
        return (w >= 3) && (a + b <= longint'(NR));
    endfunction

    function automatic logic valid_for(input int mode, input logic tog);
        if (mode == 0) return 1'b1;
        if (mode == 1) return tog;
        return logic'($urandom_range(0, 1));
    endfunction

    // Sampling point for the main process: after the monitor has run.
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every buffer write must be the next expected one, and the
    // router kick must coincide exactly with the job's final write.
    initial begin
        wr_t it;
        forever begin
            @(negedge clk);
            if (ctrl_start_o) ctrl_cnt++;
            if (wr_en_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_en", wr_en_o, 0);
                end else begin
                    it = exp_q.pop_front();
                    check("wr_addr", wr_addr_o, it.addr);
                    check("wr_data", wr_data_o, it.data);
                    check("ctrl_with_last_wr", ctrl_start_o, it.last);
                end
            end else if (ctrl_start_o) begin
                check("ctrl_without_wr", ctrl_start_o, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, s_ready_o, 0);
        check({tag, "_wr_en"}, wr_en_o, 0);
        check({tag, "_wr_addr"}, wr_addr_o, 0);
        check({tag, "_wr_data"}, wr_data_o, 0);
        check({tag, "_ctrl_start"}, ctrl_start_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    task automatic cfg_pulse(input int w);
        @(posedge clk); #1;
        cfg_start_i     = 1'b1;
        cfg_ifmap_width = 16'(w);
        @(posedge clk); #1;
        cfg_start_i     = 1'b0;
    endtask

    task automatic reject_job(input int w);
        cfg_pulse(w);
        sample();
        check("rej_err_pulse", err_o, 1);
        check("rej_busy", busy_o, 0);
        check("rej_s_ready", s_ready_o, 0);
        sample();
        check("rej_err_clear", err_o, 0);
        check("rej_busy_after", busy_o, 0);
        check("rej_s_ready_after", s_ready_o, 0);
    endtask

    // One job: mode 0 continuous, 1 toggling, 2 random valid.
    // abort_after > 0 resets the block after that many accepted pixels.
    task automatic run_job(input int w, input int mode, input bit fixed,
                           input bit disturb, input int abort_after);
        int   n;
        int   nsend;
        int   pix[$];
        logic tog;
        bit   accepted;
        int   guard;
        wr_t  e;
        n     = w * w;
        nsend = (abort_after > 0) ? abort_after : n;
        for (int i = 0; i < n; i++) pix.push_back(fixed ? (i + 1) : int'($urandom_range(0, 255)));
        ctrl_cnt = 0;
        for (int i = 0; i < nsend; i++) begin
            e.addr = i;
            e.data = pix[i];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        cfg_pulse(w);
        sample();
        check("job_err", err_o, 0);
        check("job_busy", busy_o, 1);
        check("job_s_ready", s_ready_o, 1);
        @(posedge clk); #1;
        tog = 1'b1;
        for (int i = 0; i < nsend; i++) begin
            s_data_i = DW'(pix[i]);
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 64) begin
                s_valid_i = valid_for(mode, tog);
                if (disturb && i == 3) begin
                    cfg_start_i     = 1'b1;
                    cfg_ifmap_width = 16'd4;
                    flag_done_i     = 1'b1;
                end
                sample();
                accepted = s_valid_i && s_ready_o;
                @(posedge clk); #1;
                tog         = ~tog;
                guard++;
                cfg_start_i = 1'b0;
                flag_done_i = 1'b0;
            end
            if (!accepted) begin
                check("accept_timeout", accepted, 1);
                s_valid_i = 1'b0;
                return;
            end
        end
        if (abort_after > 0) begin
            nrst      = 1'b0;
            s_valid_i = 1'b0;
            @(posedge clk);
            sample();
            check_all_zero("abort");
            check("abort_writes_drained", exp_q.size(), 0);
            @(posedge clk); #1;
            nrst = 1'b1;
            return;
        end
        // Keep offering junk: nothing more may be accepted for this job.
        s_valid_i = 1'b1;
        s_data_i  = 8'hEE;
        guard     = 0;
        sample();
        while (exp_q.size() != 0 && guard < 8) begin
            sample();
            guard++;
        end
        check("writes_drained", exp_q.size(), 0);
        for (int k = 0; k < 5; k++) begin
            sample();
            check("wait_busy", busy_o, 1);
            check("wait_done", done_o, 0);
            check("wait_s_ready", s_ready_o, 0);
        end
        check("ctrl_start_count", ctrl_cnt, 1);
        s_valid_i = 1'b0;
        @(posedge clk); #1;
        flag_done_i = 1'b1;
        @(posedge clk); #1;
        flag_done_i = 1'b0;
        sample();
        check("done_pulse", done_o, 1);
        check("done_busy", busy_o, 1);
        sample();
        check("done_clear", done_o, 0);
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        int w;
        nrst            = 1'b0;
        s_data_i        = '0;
        s_valid_i       = 1'b0;
        cfg_ifmap_width = 16'd0;
        cfg_start_i     = 1'b0;
        flag_done_i     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sample();
        check_all_zero("reset");
        @(posedge clk); #1;
        nrst = 1'b1;

        run_job(4, 0, 1'b1, 1'b0, 0);      // continuous 0x01..0x10
        run_job(4, 1, 1'b1, 1'b0, 0);      // toggling valid
        reject_job(13);                    // 169+121 = 290 > 256
        reject_job(2);
        reject_job(0);
        reject_job(65535);                 // huge footprint must not wrap
        run_job(3, 0, 1'b0, 1'b1, 0);      // stray cfg_start/flag_done in load
        run_job(4, 0, 1'b1, 1'b0, 5);      // reset after 5 pixels
        run_job(4, 2, 1'b0, 1'b0, 0);      // restarts at address 0
        run_job(12, 2, 1'b0, 1'b0, 0);     // 144+100 = 244 words, fits
        for (int j = 0; j < 6; j++) begin
            w = int'($urandom_range(0, 16));
            if (fits(w)) run_job(w, int'($urandom_range(0, 2)), 1'b0, 1'b0, 0);
            else reject_job(w);
        end
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifmap_loader.md
IFMAP_LOADER -- requirements
Module: ifmap_loader

Interface
REQ-001 SHALL have parameter dataSize, default 8, pixel width in bits.
REQ-002 SHALL have parameter numRegister, default 256, buffer depth in words; localparam nAddress = clog2(numRegister).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port nrst, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port s_data_i, input, dataSize, ifmap pixel stream (channel, x, y order; y slowest).
REQ-006 SHALL have port s_valid_i / s_ready_o, input / output, 1 each, stream handshake; transfer when both high.
REQ-007 SHALL have port cfg_ifmap_width, input, 16, square ifmap side length; sampled at cfg_start_i.
REQ-008 SHALL have port cfg_start_i, input, 1, begin a load-and-compute job.
REQ-009 SHALL have port wr_data_o / wr_addr_o / wr_en_o, output, dataSize / nAddress / 1, buffer write port.
REQ-010 SHALL have port ctrl_start_o, output, 1, one-cycle start pulse to the router.
REQ-011 SHALL have port flag_done_i, input, 1, router completion.
REQ-012 SHALL have port busy_o / done_o / err_o, output, 1 each, status: not idle / job-finished pulse / config-rejected pulse.

Function
REQ-013 SHALL implement states S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE.
REQ-014 In S_IDLE, cfg_start_i SHALL latch width W and compute ifmap footprint W*W and ofmap footprint (W-2)*(W-2) at 32-bit width, no truncation.
REQ-015 If W<3 or W*W+(W-2)*(W-2) > numRegister, SHALL pulse err_o one cycle later and remain in S_IDLE; otherwise SHALL enter S_LOAD with pixel counter = 0.
REQ-016 s_ready_o SHALL be high only in S_LOAD; cfg_start_i SHALL be ignored outside S_IDLE.
REQ-017 Each accepted transfer SHALL produce wr_en_o=1, wr_addr_o=counter, wr_data_o=s_data_i in the following cycle (latency 1, registered); counter increments by 1.
REQ-018 Gaps in s_valid_i SHALL stall loading without writes; wr_en_o=0 in cycles with no preceding transfer.
REQ-019 On accepting pixel W*W-1, SHALL move to S_START and deassert s_ready_o in that next cycle; no further pixel accepted for the job.
REQ-020 S_START SHALL last exactly one cycle with ctrl_start_o=1, coincident with the last wr_en_o, then enter S_WAIT.
REQ-021 In S_WAIT, flag_done_i=1 SHALL move to S_DONE; flag_done_i SHALL be ignored in all other states.
REQ-022 S_DONE SHALL last one cycle with done_o=1, then return to S_IDLE.
REQ-023 busy_o SHALL be 1 in every state except S_IDLE.
REQ-024 Counter and wr_addr_o SHALL be nAddress bits; footprint check guarantees no wrap.

Reset
REQ-025 With nrst low at a clock edge, SHALL enter S_IDLE, clear counter and latched width, and drive s_ready_o, wr_en_o, wr_addr_o, wr_data_o, ctrl_start_o, busy_o, done_o, err_o to 0 the following cycle.
REQ-026 Reset mid-job SHALL abandon the job; no write or ctrl_start_o after reset; next job restarts at address 0.

Structure
REQ-027 State enum and a footprint-check function SHALL live in shared package accel_pkg for reuse by the ofmap writeback path.
REQ-028 SHALL be a single module with no sub-module; FSM and datapath flopped separately.

Verification
REQ-029 W=4, pixels 0x01..0x10 with continuous valid -> 16 writes addr 0..15, data 0x01..0x10; ctrl_start_o pulses with addr 15 write; flag_done_i 5 cycles later -> done_o pulse next cycle, busy_o falls.
REQ-030 W=4, valid toggling every other cycle -> same 16 writes, no extra wr_en_o, ctrl_start_o only after 16th write.
REQ-031 cfg_start_i with W=13 (290>256) and with W=2 -> err_o pulse, busy_o stays 0, s_ready_o stays 0.
REQ-032 cfg_start_i and flag_done_i pulsed during S_LOAD at W=3 -> ignored; 9 writes then ctrl_start_o.
REQ-033 nrst low after 5 of 16 pixels (W=4) -> all outputs 0 next cycle; new job writes from addr 0.
REQ-034 W=12 (244 words) -> accepted, 144 writes addr 0..143, ctrl_start_o once.
